// File: rtl/fc_outneuron_writer_param_2.sv
// Output-neuron writer: packs accepted result words into even/odd address pairs
// of a true dual-port RAM, one layer pass per start pulse.
//
// state | meaning
// IDLE  | waiting for start, not accepting words
// EVEN  | next word goes to an even address, held until its odd partner arrives
// ODD   | next word completes the pair; both ports written together
// DONE  | final write issued this cycle, done pulse
module fc_outneuron_writer_param_2 #(
    parameter int DATA_WIDTH              = 16,
    parameter int PO                      = 2,
    parameter int OUTNEURON               = 64,
    parameter int FC_OUTNEURON_ADDR_WIDTH = 6
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                start,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [PO*DATA_WIDTH-1:0]            in_data,
    output logic                                wea,
    output logic [FC_OUTNEURON_ADDR_WIDTH-1:0]  addra,
    output logic [PO*DATA_WIDTH-1:0]            dina,
    output logic                                web,
    output logic [FC_OUTNEURON_ADDR_WIDTH-1:0]  addrb,
    output logic [PO*DATA_WIDTH-1:0]            dinb,
    output logic                                busy,
    output logic                                done
);
    localparam int WORDS = OUTNEURON / PO;
    localparam int AW    = FC_OUTNEURON_ADDR_WIDTH;
    localparam int DW    = PO * DATA_WIDTH;
    localparam logic [AW-1:0] LAST = AW'(WORDS - 1);
    localparam logic [AW-1:0] ONE  = AW'(1);

    typedef enum logic [1:0] {IDLE, EVEN, ODD, DONE} state_t;

    state_t          state, state_nxt;
    logic [AW-1:0]   cnt, cnt_nxt;
    logic [DW-1:0]   hold, hold_nxt;
    logic            wea_nxt, web_nxt;
    logic [AW-1:0]   addra_nxt, addrb_nxt;
    logic [DW-1:0]   dina_nxt, dinb_nxt;
    logic            accept;

    assign in_ready = (state == EVEN) || (state == ODD);
    assign busy     = (state != IDLE);
    assign done     = (state == DONE);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            hold  <= '0;
            wea   <= 1'b0;
            web   <= 1'b0;
            addra <= '0;
            addrb <= ONE;
            dina  <= '0;
            dinb  <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            hold  <= hold_nxt;
            wea   <= wea_nxt;
            web   <= web_nxt;
            addra <= addra_nxt;
            addrb <= addrb_nxt;
            dina  <= dina_nxt;
            dinb  <= dinb_nxt;
        end
    end

    // Strobes default low; addresses and data hold between writes.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        hold_nxt  = hold;
        wea_nxt   = 1'b0;
        web_nxt   = 1'b0;
        addra_nxt = addra;
        addrb_nxt = addrb;
        dina_nxt  = dina;
        dinb_nxt  = dinb;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = EVEN;
                    cnt_nxt   = '0;
                end
            end
            EVEN: begin
                if (accept) begin
                    hold_nxt = in_data;
                    if (cnt == LAST) begin
                        // odd word count: last word has no partner
                        wea_nxt   = 1'b1;
                        addra_nxt = cnt;
                        dina_nxt  = in_data;
                        state_nxt = DONE;
                    end else begin
                        cnt_nxt   = cnt + ONE;
                        state_nxt = ODD;
                    end
                end
            end
            ODD: begin
                if (accept) begin
                    wea_nxt   = 1'b1;
                    web_nxt   = 1'b1;
                    addra_nxt = cnt - ONE;
                    addrb_nxt = cnt;
                    dina_nxt  = hold;
                    dinb_nxt  = in_data;
                    if (cnt == LAST) begin
                        state_nxt = DONE;
                    end else begin
                        cnt_nxt   = cnt + ONE;
                        state_nxt = EVEN;
                    end
                end
            end
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end
endmodule
